// File: rtl/mul_serial_acc.sv
// mul_serial_acc -- signed bit-serial multiplier with valid/ready handshakes.
//
// Accepts two WIDTH-bit two's-complement operands, walks the multiplier
// (i_data0) BITS_PER_CYC bits per enabled cycle, LSB digit first, and adds the
// shifted partial products of the multiplicand (i_data1) into a 2*WIDTH-bit
// accumulator. The full signed product is offered through o_valid/o_ready.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       clock enable; low holds every register
//   clr      synchronous clear back to IDLE (wins over en)
//   i_valid  operands valid          i_ready  block can accept operands
//   i_data0  signed multiplier       i_data1  signed multiplicand
//   o_valid  product valid           o_ready  downstream accepts product
//   o_data   signed 2*WIDTH product  o_idx    digit index being processed
//   o_busy   high while digits are being processed
//
// Optional feature macro: MUL_ZERO_SKIP_EN
//   When defined, a run ends early as soon as every multiplier bit above the
//   current digit is zero. Negative multipliers have the MSB set and therefore
//   always use all digits. When undefined, every run takes WIDTH/BITS_PER_CYC
//   enabled cycles.

module mul_serial_acc #(
  parameter int WIDTH        = 8,
  parameter int BITS_PER_CYC = 1,
  parameter int DEPTH        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [WIDTH-1:0]     i_data0,
  input  logic [WIDTH-1:0]     i_data1,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [2*WIDTH-1:0]   o_data,
  output logic [DEPTH-1:0]     o_idx,
  output logic                 o_busy
);

  localparam int N  = WIDTH / BITS_PER_CYC;
  localparam int PW = 2 * WIDTH;
  localparam int B  = BITS_PER_CYC;
  localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     data_q, data_d;
  logic [DEPTH-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic [B-1:0]      digit;
  logic [B:0]        digit_ext;
  logic              last_digit;
  logic              run_last;
  logic [PW-1:0]     pp_a;
  logic [PW-1:0]     pp_b;
  logic [PW-1:0]     pp_full;
  logic [PW-1:0]     pp_sh;
  logic [PW-1:0]     acc_sum;
`ifdef MUL_ZERO_SKIP_EN
  logic [WIDTH-1:0]  upper_bits;
`endif

  // Partial product of the current digit and the accumulator update.
  always_comb begin
    digit      = B'(a_q >> (32'(idx_q) * B));
    last_digit = (idx_q == LAST_IDX);
    // The top digit carries the operand sign; lower digits are plain magnitudes.
    if (last_digit) begin
      digit_ext = {digit[B-1], digit};
    end else begin
      digit_ext = {1'b0, digit};
    end
    // Both factors are sign-extended to the product width so the low PW bits
    // of an unsigned multiply are the correct two's-complement result.
    pp_a    = {{(PW-B-1){digit_ext[B]}}, digit_ext};
    pp_b    = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    pp_full = pp_a * pp_b;
    pp_sh   = pp_full << (32'(idx_q) * B);
    acc_sum = acc_q + pp_sh;
`ifdef MUL_ZERO_SKIP_EN
    upper_bits = a_q >> ((32'(idx_q) + 32'd1) * B);
    run_last   = last_digit || (upper_bits == {WIDTH{1'b0}});
`else
    run_last   = last_digit;
`endif
  end

  // Next-state and output decode; clr outranks en.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    if (clr) begin
      state_d = ST_IDLE;
      a_d     = {WIDTH{1'b0}};
      b_d     = {WIDTH{1'b0}};
      acc_d   = {PW{1'b0}};
      data_d  = {PW{1'b0}};
      idx_d   = {DEPTH{1'b0}};
      valid_d = 1'b0;
      busy_d  = 1'b0;
      ready_d = 1'b1;
    end else if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            state_d = ST_RUN;
            a_d     = i_data0;
            b_d     = i_data1;
            acc_d   = {PW{1'b0}};
            idx_d   = {DEPTH{1'b0}};
            busy_d  = 1'b1;
            ready_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_d = acc_sum;
          idx_d = idx_q + DEPTH'(1);
          if (run_last) begin
            state_d = ST_DONE;
            data_d  = acc_sum;
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (o_ready) begin
            state_d = ST_IDLE;
            idx_d   = {DEPTH{1'b0}};
            valid_d = 1'b0;
            ready_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = {DEPTH{1'b0}};
          valid_d = 1'b0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {PW{1'b0}};
      data_q  <= {PW{1'b0}};
      idx_q   <= {DEPTH{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign i_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_idx   = idx_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_mul_serial_acc.sv
// Testbench for mul_serial_acc: three instances (1, 2 and 8 bits per cycle)
// share one stimulus stream; the 1-bit instance is checked every cycle against
// a behavioural model, and every transaction is checked for product/latency.
module tb_mul_serial_acc;

`ifdef MUL_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en, clr, i_valid, o_ready;
  logic [7:0]  i_data0, i_data1;

  logic        o_valid, i_ready, o_busy;
  logic [15:0] o_data;
  logic [2:0]  o_idx;
  logic        d2_valid, d2_ready, d2_busy;
  logic [15:0] d2_data;
  logic [1:0]  d2_idx;
  logic        d8_valid, d8_ready, d8_busy;
  logic [15:0] d8_data;
  logic [0:0]  d8_idx;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mul_serial_acc #(.WIDTH(8), .BITS_PER_CYC(1), .DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i_valid(i_valid),
    .i_ready(i_ready), .i_data0(i_data0), .i_data1(i_data1), .o_valid(o_valid),
    .o_ready(o_ready), .o_data(o_data), .o_idx(o_idx), .o_busy(o_busy));

  mul_serial_acc #(.WIDTH(8), .BITS_PER_CYC(2), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i_valid(i_valid),
    .i_ready(d2_ready), .i_data0(i_data0), .i_data1(i_data1), .o_valid(d2_valid),
    .o_ready(o_ready), .o_data(d2_data), .o_idx(d2_idx), .o_busy(d2_busy));

  mul_serial_acc #(.WIDTH(8), .BITS_PER_CYC(8), .DEPTH(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i_valid(i_valid),
    .i_ready(d8_ready), .i_data0(i_data0), .i_data1(i_data1), .o_valid(d8_valid),
    .o_ready(o_ready), .o_data(d8_data), .o_idx(d8_idx), .o_busy(d8_busy));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signed product by plain integer arithmetic.
  function automatic logic [15:0] mulp(input logic [7:0] a, input logic [7:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    return 16'(x * y);
  endfunction

  // Cycles a run needs for multiplier a with b bits per cycle.
  function automatic int lat_of(input logic [7:0] a, input int b);
    int h;
    h = 0;
    for (int k = 0; k < 8; k++) if (a[k]) h = k;
    return SKIP ? (h / b + 1) : (8 / b);
  endfunction

  // Behavioural model of the 1-bit instance: mode 0 idle, 1 running, 2 done.
  int          m_mode = 0, m_cnt = 0, m_lat = 8;
  logic [15:0] m_prod = 16'h0, m_out = 16'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_cnt <= 0; m_out <= 16'h0;
    end else if (clr) begin
      m_mode <= 0; m_cnt <= 0; m_out <= 16'h0;
    end else if (en) begin
      if (m_mode == 0) begin
        if (i_valid) begin
          m_mode <= 1; m_cnt <= 0;
          m_prod <= mulp(i_data0, i_data1);
          m_lat  <= lat_of(i_data0, 1);
        end
      end else if (m_mode == 1) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == m_lat) begin
          m_mode <= 2; m_out <= m_prod;
        end
      end else if (o_ready) begin
        m_mode <= 0; m_cnt <= 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("o_valid", 32'(o_valid), 32'(m_mode == 2));
    chk("i_ready", 32'(i_ready), 32'(m_mode == 0));
    chk("o_busy",  32'(o_busy),  32'(m_mode == 1));
    chk("o_idx",   32'(o_idx),   (m_mode == 0) ? 32'd0 : 32'(m_cnt % 8));
    chk("o_data",  32'(o_data),  32'(m_out));
  end

  // One transaction on all three instances; returns total and per-instance latencies.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                       input int lat_main, input bit stall, input bit rnd, input int hold,
                       output int tot, output int c2, output int c8);
    int guard, cnt, ecnt;
    bit e_now;
    guard = 0;
    while (!i_ready && guard < 50) begin
      @(negedge clk); guard++;
    end
    if (guard >= 50) chk("idle_wait", 32'(i_ready), 32'd1);
    en = 1'b1; i_valid = 1'b1; i_data0 = a; i_data1 = b;
    @(negedge clk);
    i_valid = 1'b0;
    cnt = 0; ecnt = 0; c2 = 0; c8 = 0;
    while (!o_valid && cnt < 40) begin
      if (stall) en = !(cnt >= 3 && cnt < 6);
      else if (rnd) en = ($urandom_range(0, 5) != 0);
      else en = 1'b1;
      if (rnd) begin
        i_valid = 1'($urandom_range(0, 1)); i_data0 = 8'($urandom); i_data1 = 8'($urandom);
      end
      e_now = en;
      @(negedge clk);
      cnt++;
      if (e_now) ecnt++;
      if (d2_valid && c2 == 0) c2 = ecnt;
      if (d8_valid && c8 == 0) c8 = ecnt;
    end
    i_valid = 1'b0; en = 1'b1;
    if (cnt >= 40) chk("done_timeout", 32'(o_valid), 32'd1);
    tot = cnt;
    chk("latency",  32'(ecnt), 32'(lat_main));
    chk("product",  32'(o_data), 32'(exp));
    chk("d2_data",  32'(d2_data), 32'(exp));
    chk("d8_data",  32'(d8_data), 32'(exp));
    chk("d2_lat",   32'(c2), 32'(lat_of(a, 2)));
    chk("d8_lat",   32'(c8), 32'(lat_of(a, 8)));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid",  32'(o_valid), 32'd1);
      chk("hold_data",   32'(o_data), 32'(exp));
      chk("hold_iready", 32'(i_ready), 32'd0);
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    chk("handoff_valid",  32'(o_valid), 32'd0);
    chk("handoff_iready", 32'(i_ready), 32'd1);
  endtask

  // Start a run and stop once the 1-bit instance reports digit 4.
  task automatic start_to_idx4();
    int guard;
    i_valid = 1'b1; i_data0 = 8'h55; i_data1 = 8'h21;
    @(negedge clk);
    i_valid = 1'b0;
    guard = 0;
    while (o_idx != 3'd4 && guard < 20) begin
      @(negedge clk); guard++;
    end
    if (guard >= 20) chk("idx4_wait", 32'(o_idx), 32'd4);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_iready"}, 32'(i_ready), 32'd1);
    chk({nm, "_valid"},  32'(o_valid), 32'd0);
    chk({nm, "_busy"},   32'(o_busy), 32'd0);
    chk({nm, "_idx"},    32'(o_idx), 32'd0);
    chk({nm, "_data"},   32'(o_data), 32'd0);
    chk({nm, "_d2"},     {d2_ready, d2_valid, d2_busy, d2_idx}, 32'b10000);
    chk({nm, "_d8"},     {d8_ready, d8_valid, d8_busy, d8_idx}, 32'b1000);
  endtask

  initial begin
    int tot, c2, c8;
    logic [7:0] a, b;
    logic [7:0] corners [5];
    corners = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01};
    en = 1'b1; clr = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    i_data0 = 8'h00; i_data1 = 8'h00;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and sign corners.
    do_op(8'd7, 8'd9, 16'h003F, SKIP ? 3 : 8, 1'b0, 1'b0, 0, tot, c2, c8);
    chk("lat_7x9_total", 32'(tot), SKIP ? 32'd3 : 32'd8);
    do_op(8'h80, 8'h80, 16'h4000, 8, 1'b0, 1'b0, 0, tot, c2, c8);
    do_op(8'h80, 8'h7F, 16'hC080, 8, 1'b0, 1'b0, 0, tot, c2, c8);
    do_op(8'hFF, 8'd5,  16'hFFFB, 8, 1'b0, 1'b0, 0, tot, c2, c8);
    // Multi-bit digit instances.
    do_op(8'd100, 8'hFD, 16'hFED4, SKIP ? 7 : 8, 1'b0, 1'b0, 0, tot, c2, c8);
    chk("b2_lat_100", 32'(c2), 32'd4);
    do_op(8'hF9, 8'd6, 16'hFFD6, 8, 1'b0, 1'b0, 0, tot, c2, c8);
    chk("b8_lat_m7", 32'(c8), 32'd1);
    // Stall and backpressure.
    do_op(8'h85, 8'd3, 16'hFE8F, 8, 1'b1, 1'b0, 0, tot, c2, c8);
    chk("stall_total", 32'(tot), 32'd11);
    do_op(8'd25, 8'hFC, 16'hFF9C, SKIP ? 5 : 8, 1'b0, 1'b0, 5, tot, c2, c8);

    // Synchronous clear mid-run, then recovery.
    start_to_idx4();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk_idle("clr");
    do_op(8'd3, 8'd3, 16'd9, SKIP ? 2 : 8, 1'b0, 1'b0, 0, tot, c2, c8);

    // Asynchronous reset mid-run, then recovery.
    start_to_idx4();
    #1 rst_n = 1'b0;
    #1 chk_idle("arst");
    #1 rst_n = 1'b1;
    @(negedge clk);
    do_op(8'd3, 8'd3, 16'd9, SKIP ? 2 : 8, 1'b0, 1'b0, 0, tot, c2, c8);

    // Early-finish cases (full length without the feature).
    do_op(8'd1,  8'd55, 16'd55,   SKIP ? 1 : 8, 1'b0, 1'b0, 0, tot, c2, c8);
    do_op(8'h10, 8'd3,  16'd48,   SKIP ? 5 : 8, 1'b0, 1'b0, 0, tot, c2, c8);
    do_op(8'hFE, 8'd3,  16'hFFFA, 8,            1'b0, 1'b0, 0, tot, c2, c8);

    // Randomized operands, enables, ignored inputs and backpressure.
    for (int n = 0; n < 60; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = corners[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) b = corners[$urandom_range(0, 4)];
      do_op(a, b, mulp(a, b), lat_of(a, 1), 1'b0, 1'b1, int'($urandom_range(0, 3)),
            tot, c2, c8);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout vectors=%0d miscompares=%0d", vec, errs);
    $fatal(1, "watchdog");
  end

endmodule
